// File: rtl/uart_rx_sampler_if.sv
// Received-byte stream of uart_rx_sampler.
// data_o/valid_o go toward the consumer, and ready_i comes back from it.
interface uart_rx_sampler_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;

  modport master (output data_o, output valid_o, input ready_i);
  modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/uart_rx_sampler.sv
// UART receiver: 2-flop sync, centre sampling, 8N1 (8E1 when UART_RX_PARITY_EN is defined).
// Latency: valid_o rises 3 cycles after the stop-bit centre reaches rx_pin_i.
// Backpressure: one holding register; a byte completing while it is unaccepted is dropped and overrun_o is set.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_pin_i,
  uart_rx_sampler_if.master rx_out,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic              parity_err_o,
  input  logic              err_clr_i
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  logic [1:0]           sync_q;
  logic                 rx_s;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q, overrun_q, parity_err_q;
  logic                 tick, deliver, frame_set, par_set, overrun_set, accept_new;

  assign rx_s = sync_q[1];
  assign tick = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q - CW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    deliver   = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = HALF;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            cnt_d     = FULL;
            idx_d     = '0;
            par_bad_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          // LSB arrives first, so shifting in at the top leaves bit 0 at the bottom
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = FULL;
          idx_d   = idx_q + BW'(1);
          if (idx_q == LAST) state_d = AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_set   = (^shift_q) ^ rx_s;
          par_bad_d = par_set;
          cnt_d     = FULL;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            deliver = !par_bad_q;
            state_d = IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept_new  = deliver && (!valid_q || rx_out.ready_i);
  assign overrun_set = deliver && valid_q && !rx_out.ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q       <= 2'b11;
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_pin_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      if (accept_new) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && rx_out.ready_i) begin
        valid_q <= 1'b0;
      end
      // a new error event in the clear cycle must survive the clear
      frame_err_q  <= frame_set   | (frame_err_q  & ~err_clr_i);
      overrun_q    <= overrun_set | (overrun_q    & ~err_clr_i);
      parity_err_q <= par_set     | (parity_err_q & ~err_clr_i);
    end
  end

  assign rx_out.data_o  = data_q;
  assign rx_out.valid_o = valid_q;
  assign busy_o         = (state_q != IDLE);
  assign frame_err_o    = frame_err_q;
  assign overrun_o      = overrun_q;
  assign parity_err_o   = parity_err_q;
endmodule
